// File: rtl/div_share_arbiter.sv
// Round-robin front end that shares one 4-bit sequential divider among N
// requesters, sequencing Go/ResultValid and returning results per requester.
module div_share_arbiter #(
    parameter int N       = 2,
    parameter int TIMEOUT = 15
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [4*N-1:0]   req_divisor,
    input  logic [4*N-1:0]   req_dividend,
    output logic [N-1:0]     resp_valid,
    input  logic [N-1:0]     resp_ready,
    output logic [3:0]       resp_quotient,
    output logic [3:0]       resp_remainder,
    output logic             resp_dbz,
    output logic             resp_err,
    output logic             div_go,
    output logic [3:0]       div_divisor,
    output logic [3:0]       div_dividend,
    input  logic [3:0]       div_quotient,
    input  logic [3:0]       div_remainder,
    input  logic             div_result_valid,
    output logic             busy
);
    localparam int PW = (N > 2) ? 2 : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [PW:0] NUM_REQ = (PW + 1)'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic [3:0]      r_divisor;
    logic [3:0]      r_dividend;
    logic [3:0]      r_quot;
    logic [3:0]      r_rem;
    logic            r_dbz;
    logic            r_err;
    logic [CW-1:0]   r_cnt;

    logic [3:0]      w_op_divisor  [N];
    logic [3:0]      w_op_dividend [N];
    logic [PW-1:0]   w_grant;
    logic [PW:0]     w_idx;
    logic            w_any;
    logic [3:0]      w_sel_divisor;
    logic [3:0]      w_sel_dividend;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_timeout;
    logic            w_owner_ack;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_req
            assign w_op_divisor[gi]  = req_divisor[4*gi +: 4];
            assign w_op_dividend[gi] = req_dividend[4*gi +: 4];
            assign resp_valid[gi]    = (r_state == S_RESP) && (r_owner == PW'(gi));
        end
    endgenerate

    // Scan from the farthest offset down so the nearest valid requester after the pointer wins.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = {1'b0, r_ptr} + (PW + 1)'(k);
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (req_valid[w_idx[PW-1:0]]) begin
                w_any   = 1'b1;
                w_grant = w_idx[PW-1:0];
            end
        end
    end

    assign w_sel_divisor  = w_op_divisor[w_grant];
    assign w_sel_dividend = w_op_dividend[w_grant];
    assign w_cnt_inc      = r_cnt + 1'b1;
    assign w_timeout      = (w_cnt_inc == CW'(TIMEOUT));
    assign w_owner_ack    = resp_ready[r_owner];

    always_comb begin
        w_state_next = r_state;
        req_ready    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    req_ready[w_grant] = 1'b1;
                    w_state_next = (w_sel_divisor == 4'd0) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (w_timeout) begin
                    w_state_next = S_RESP;
                end else if (!div_result_valid) begin
                    w_state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (w_timeout || div_result_valid) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (w_owner_ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state    <= S_IDLE;
            r_ptr      <= PW'(N - 1);
            r_owner    <= '0;
            r_divisor  <= '0;
            r_dividend <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_dbz      <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ptr      <= w_grant;
                        r_owner    <= w_grant;
                        r_divisor  <= w_sel_divisor;
                        r_dividend <= w_sel_dividend;
                        // A zero divisor never reaches the divider; the result is formed here.
                        if (w_sel_divisor == 4'd0) begin
                            r_quot <= 4'hF;
                            r_rem  <= w_sel_dividend;
                            r_dbz  <= 1'b1;
                            r_err  <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT_BUSY, S_WAIT_DONE: begin
                    r_cnt <= w_cnt_inc;
                    if (w_timeout) begin
                        r_quot <= '0;
                        r_rem  <= '0;
                        r_dbz  <= 1'b0;
                        r_err  <= 1'b1;
                    end else if ((r_state == S_WAIT_DONE) && div_result_valid) begin
                        r_quot <= div_quotient;
                        r_rem  <= div_remainder;
                        r_dbz  <= 1'b0;
                        r_err  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign div_go         = (r_state == S_ISSUE);
    assign busy           = (r_state != S_IDLE);
    assign div_divisor    = r_divisor;
    assign div_dividend   = r_dividend;
    assign resp_quotient  = r_quot;
    assign resp_remainder = r_rem;
    assign resp_dbz       = r_dbz;
    assign resp_err       = r_err;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: behavioural divider stub plus directed and
// randomized scenarios checked against a round-robin/arithmetic reference.
module tb_div_share_arbiter;
    localparam int N       = 2;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              Resetn;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [4*N-1:0]    req_divisor;
    logic [4*N-1:0]    req_dividend;
    logic [N-1:0]      resp_valid;
    logic [N-1:0]      resp_ready;
    logic [3:0]        resp_quotient;
    logic [3:0]        resp_remainder;
    logic              resp_dbz;
    logic              resp_err;
    logic              div_go;
    logic [3:0]        div_divisor;
    logic [3:0]        div_dividend;
    logic [3:0]        div_quotient = 4'd0;
    logic [3:0]        div_remainder = 4'd0;
    logic              div_result_valid = 1'b1;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int go_count = 0;
    logic stub_stuck = 1'b0;
    int stub_cnt = 0;

    always #5 clk = ~clk;

    div_share_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .Clock(clk), .Resetn(Resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_divisor(req_divisor), .req_dividend(req_dividend),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
        .resp_dbz(resp_dbz), .resp_err(resp_err),
        .div_go(div_go), .div_divisor(div_divisor), .div_dividend(div_dividend),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_result_valid(div_result_valid), .busy(busy)
    );

    // Divider stub: ResultValid drops the cycle after Go and returns 4 cycles later.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (div_go === 1'b1) go_count <= go_count + 1;
        if (stub_stuck) begin
            div_result_valid <= 1'b1;
            div_quotient     <= 4'h5;
            div_remainder    <= 4'h9;
            stub_cnt         <= 0;
        end else if (div_go === 1'b1) begin
            div_result_valid <= 1'b0;
            stub_cnt         <= 4;
            if (div_divisor == 4'd0) begin
                div_quotient  <= 4'hF;
                div_remainder <= div_dividend;
            end else begin
                div_quotient  <= div_dividend / div_divisor;
                div_remainder <= div_dividend % div_divisor;
            end
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) div_result_valid <= 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Resetn = 1'b0; req_valid = '0; resp_ready = '0;
        step(); step();
        Resetn = 1'b1;
    endtask

    task automatic set_op(input int i, input logic [3:0] divisor, input logic [3:0] dividend);
        req_divisor[4*i +: 4]  = divisor;
        req_dividend[4*i +: 4] = dividend;
    endtask

    task automatic wait_resp(input int lim, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < lim; t++) begin
            if (resp_valid != '0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        req_divisor = '0; req_dividend = '0;
        do_reset();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (req_ready !== '0 || resp_valid !== '0) begin errors++; $display("FAIL reset_handshake: ready %b valid %b want 0", req_ready, resp_valid); end
        checks++; if (div_go !== 1'b0) begin errors++; $display("FAIL reset_go: got %b want 0", div_go); end
        checks++; if (resp_quotient !== 4'd0 || resp_remainder !== 4'd0) begin errors++; $display("FAIL reset_result: q %h r %h want 0", resp_quotient, resp_remainder); end
        checks++; if (resp_dbz !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_flags: dbz %b err %b want 0", resp_dbz, resp_err); end
        checks++; if (div_divisor !== 4'd0 || div_dividend !== 4'd0) begin errors++; $display("FAIL reset_operands: %h %h want 0", div_divisor, div_dividend); end
    endtask

    task automatic test_single();
        int acc, g0;
        bit ok;
        resp_ready = '1;
        g0 = go_count;
        set_op(0, 4'd2, 4'd7);
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
        acc = cyc;
        step();
        req_valid = '0;
        wait_resp(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: no resp_valid"); end
        checks++; if (cyc - acc != 7) begin errors++; $display("FAIL single_latency: got %0d want 7", cyc - acc); end
        checks++; if (resp_valid !== 2'b01 || resp_quotient !== 4'd3 || resp_remainder !== 4'd1) begin
            errors++; $display("FAIL single_result: valid %b q %h r %h want 01 3 1", resp_valid, resp_quotient, resp_remainder); end
        checks++; if (resp_dbz !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL single_flags: dbz %b err %b want 0 0", resp_dbz, resp_err); end
        checks++; if (go_count - g0 != 1) begin errors++; $display("FAIL single_go: pulses %0d want 1", go_count - g0); end
        checks++; if (div_divisor !== 4'd2 || div_dividend !== 4'd7) begin errors++; $display("FAIL single_operands: %h %h want 2 7", div_divisor, div_dividend); end
        step();
        checks++; if (busy !== 1'b0 || resp_valid !== '0) begin errors++; $display("FAIL single_release: busy %b valid %b want 0", busy, resp_valid); end
        resp_ready = '0;
    endtask

    task automatic test_contention();
        bit ok;
        do_reset();
        set_op(0, 4'd4, 4'd9);
        set_op(1, 4'd3, 4'd15);
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL cont_first_grant: got %b want 01", req_ready); end
        step();
        req_valid = 2'b10;
        wait_resp(30, ok);
        checks++; if (!ok || resp_valid !== 2'b01 || resp_quotient !== 4'd2 || resp_remainder !== 4'd1) begin
            errors++; $display("FAIL cont_r0: valid %b q %h r %h want 01 2 1", resp_valid, resp_quotient, resp_remainder); end
        resp_ready = 2'b01;
        step();
        resp_ready = '0;
        set_op(0, 4'd4, 4'd12);
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL cont_second_grant: got %b want 10", req_ready); end
        step();
        req_valid = 2'b01;
        wait_resp(30, ok);
        checks++; if (!ok || resp_valid !== 2'b10 || resp_quotient !== 4'd5 || resp_remainder !== 4'd0) begin
            errors++; $display("FAIL cont_r1: valid %b q %h r %h want 10 5 0", resp_valid, resp_quotient, resp_remainder); end
        resp_ready = 2'b10;
        step();
        resp_ready = '0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL cont_third_grant: got %b want 01", req_ready); end
        step();
        req_valid = '0;
        wait_resp(30, ok);
        checks++; if (!ok || resp_valid !== 2'b01 || resp_quotient !== 4'd3 || resp_remainder !== 4'd0) begin
            errors++; $display("FAIL cont_r0b: valid %b q %h r %h want 01 3 0", resp_valid, resp_quotient, resp_remainder); end
        resp_ready = 2'b01;
        step();
        resp_ready = '0;
    endtask

    task automatic test_dbz();
        int acc, g0;
        bit ok;
        g0 = go_count;
        set_op(1, 4'd0, 4'd6);
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL dbz_ready: got %b want 10", req_ready); end
        acc = cyc;
        step();
        req_valid = '0;
        wait_resp(10, ok);
        checks++; if (!ok || cyc - acc < 1 || cyc - acc > 2) begin errors++; $display("FAIL dbz_latency: got %0d want 1..2", cyc - acc); end
        checks++; if (resp_valid !== 2'b10 || resp_quotient !== 4'hF || resp_remainder !== 4'd6) begin
            errors++; $display("FAIL dbz_result: valid %b q %h r %h want 10 f 6", resp_valid, resp_quotient, resp_remainder); end
        checks++; if (resp_dbz !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL dbz_flags: dbz %b err %b want 1 0", resp_dbz, resp_err); end
        checks++; if (go_count != g0) begin errors++; $display("FAIL dbz_go: pulses %0d want 0", go_count - g0); end
        resp_ready = 2'b10;
        step();
        resp_ready = '0;
    endtask

    task automatic test_backpressure();
        bit ok;
        set_op(0, 4'd5, 4'd13);
        req_valid = 2'b01;
        #1;
        step();
        req_valid = '0;
        wait_resp(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: no resp_valid"); end
        set_op(1, 4'd4, 4'd11);
        req_valid = 2'b10;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++; if (resp_valid !== 2'b01 || resp_quotient !== 4'd2 || resp_remainder !== 4'd3) begin
                errors++; $display("FAIL bp_hold: cycle %0d valid %b q %h r %h want 01 2 3", c, resp_valid, resp_quotient, resp_remainder); end
            checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_no_accept: cycle %0d ready %b want 00", c, req_ready); end
            step();
        end
        resp_ready = 2'b10;
        step();
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL bp_nonowner_ack: valid %b want 01", resp_valid); end
        resp_ready = 2'b01;
        step();
        resp_ready = '0;
        #1;
        checks++; if (busy !== 1'b0 || resp_valid !== '0) begin errors++; $display("FAIL bp_release: busy %b valid %b want 0 00", busy, resp_valid); end
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_next_grant: got %b want 10", req_ready); end
        step();
        req_valid = '0;
        wait_resp(30, ok);
        checks++; if (!ok || resp_valid !== 2'b10 || resp_quotient !== 4'd2 || resp_remainder !== 4'd3) begin
            errors++; $display("FAIL bp_r1: valid %b q %h r %h want 10 2 3", resp_valid, resp_quotient, resp_remainder); end
        resp_ready = 2'b10;
        step();
        resp_ready = '0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        set_op(0, 4'd5, 4'd12);
        req_valid = 2'b01;
        #1;
        step();
        req_valid = '0;
        step(); step(); step();
        Resetn = 1'b0;
        step();
        Resetn = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || div_go !== 1'b0 || resp_valid !== '0 || req_ready !== '0) begin
            errors++; $display("FAIL midrst_ctrl: busy %b go %b valid %b ready %b want 0", busy, div_go, resp_valid, req_ready); end
        checks++; if (resp_quotient !== 4'd0 || resp_remainder !== 4'd0 || resp_dbz !== 1'b0 || resp_err !== 1'b0) begin
            errors++; $display("FAIL midrst_result: q %h r %h dbz %b err %b want 0", resp_quotient, resp_remainder, resp_dbz, resp_err); end
        checks++; if (div_divisor !== 4'd0 || div_dividend !== 4'd0) begin errors++; $display("FAIL midrst_operands: %h %h want 0", div_divisor, div_dividend); end
        for (int c = 0; c < 6; c++) step();
        set_op(0, 4'd3, 4'd8);
        req_valid = 2'b01;
        #1;
        step();
        req_valid = '0;
        wait_resp(30, ok);
        checks++; if (!ok || resp_valid !== 2'b01 || resp_quotient !== 4'd2 || resp_remainder !== 4'd2 || resp_err !== 1'b0) begin
            errors++; $display("FAIL midrst_after: valid %b q %h r %h err %b want 01 2 2 0", resp_valid, resp_quotient, resp_remainder, resp_err); end
        resp_ready = 2'b01;
        step();
        resp_ready = '0;
    endtask

    task automatic test_timeout();
        int acc, g0;
        bit ok;
        stub_stuck = 1'b1;
        step();
        g0 = go_count;
        set_op(1, 4'd1, 4'd5);
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL to_ready: got %b want 10", req_ready); end
        acc = cyc;
        step();
        req_valid = '0;
        wait_resp(60, ok);
        checks++; if (!ok || cyc - acc != TIMEOUT + 2) begin errors++; $display("FAIL to_latency: got %0d want %0d", cyc - acc, TIMEOUT + 2); end
        checks++; if (resp_valid !== 2'b10 || resp_err !== 1'b1 || resp_dbz !== 1'b0) begin
            errors++; $display("FAIL to_flags: valid %b err %b dbz %b want 10 1 0", resp_valid, resp_err, resp_dbz); end
        checks++; if (resp_quotient !== 4'd0 || resp_remainder !== 4'd0) begin
            errors++; $display("FAIL to_result: q %h r %h want 0 0", resp_quotient, resp_remainder); end
        checks++; if (go_count - g0 != 1) begin errors++; $display("FAIL to_go: pulses %0d want 1", go_count - g0); end
        resp_ready = 2'b10;
        step();
        resp_ready = '0;
        stub_stuck = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [3:0] pa [N];
        logic [3:0] pb [N];
        logic [N-1:0] pend;
        logic [N-1:0] exp_hot;
        logic [3:0] exp_q, exp_r;
        logic exp_dbz;
        int last, g, idx;
        bit ok;
        do_reset();
        pend = '0;
        last = N - 1;
        for (int rnd = 0; rnd < 30; rnd++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pa[i] = 4'($urandom_range(0, 15));
                    pb[i] = ($urandom_range(0, 6) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                end
            end
            if (pend == '0) begin
                idx = $urandom_range(0, N - 1);
                pend[idx] = 1'b1;
                pa[idx] = 4'($urandom_range(0, 15));
                pb[idx] = 4'($urandom_range(1, 15));
            end
            for (int i = 0; i < N; i++) set_op(i, pb[i], pa[i]);
            req_valid = pend;
            #1;
            g = -1;
            for (int k = 1; k <= N; k++) begin
                idx = (last + k) % N;
                if (pend[idx] && g < 0) g = idx;
            end
            exp_hot = '0;
            exp_hot[g] = 1'b1;
            checks++; if (req_ready !== exp_hot) begin errors++; $display("FAIL rnd_grant: round %0d got %b want %b", rnd, req_ready, exp_hot); end
            last = g;
            if (pb[g] == 4'd0) begin
                exp_q = 4'hF; exp_r = pa[g]; exp_dbz = 1'b1;
            end else begin
                exp_q = pa[g] / pb[g]; exp_r = pa[g] % pb[g]; exp_dbz = 1'b0;
            end
            step();
            pend[g] = 1'b0;
            req_valid = pend;
            set_op(g, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            #1;
            ok = 1'b0;
            for (int t = 0; t < 30; t++) begin
                if (resp_valid != '0) begin
                    ok = 1'b1;
                    break;
                end
                checks++; if (req_ready !== '0) begin errors++; $display("FAIL rnd_busy_accept: round %0d ready %b want 0", rnd, req_ready); end
                step();
            end
            checks++; if (!ok) begin errors++; $display("FAIL rnd_timeout: round %0d no resp_valid", rnd); end
            checks++; if (resp_valid !== exp_hot || resp_quotient !== exp_q || resp_remainder !== exp_r) begin
                errors++; $display("FAIL rnd_result: round %0d valid %b q %h r %h want %b %h %h", rnd, resp_valid, resp_quotient, resp_remainder, exp_hot, exp_q, exp_r); end
            checks++; if (resp_dbz !== exp_dbz || resp_err !== 1'b0) begin
                errors++; $display("FAIL rnd_flags: round %0d dbz %b err %b want %b 0", rnd, resp_dbz, resp_err, exp_dbz); end
            for (int h = $urandom_range(0, 3); h > 0; h--) begin
                resp_ready = N'($urandom) & ~exp_hot;
                step();
                checks++; if (resp_valid !== exp_hot) begin errors++; $display("FAIL rnd_hold: round %0d valid %b want %b", rnd, resp_valid, exp_hot); end
            end
            resp_ready = exp_hot | N'($urandom);
            step();
            resp_ready = '0;
        end
        req_valid = '0;
    endtask

    initial begin
        Resetn = 1'b0;
        req_valid = '0;
        resp_ready = '0;
        req_divisor = '0;
        req_dividend = '0;
        test_reset();
        test_single();
        test_contention();
        test_dbz();
        test_backpressure();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
